// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - shared enums and helpers for the multiply/divide unit
package mult_div_unit_pkg;

    typedef enum logic {
        RISING  = 1'b0,
        FALLING = 1'b1
    } ClockEdge;

    typedef enum logic [1:0] {
        MULT  = 2'd0,
        MULTU = 2'd1,
        DIV   = 2'd2,
        DIVU  = 2'd3
    } MulDivOp;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        FINISH  = 2'd2
    } MulDivState;

    // Number of bits needed to hold the unsigned value 'value'.
    function automatic int GetMinWidth(input int value);
        int width;
        width = 1;
        while ((1 << width) <= value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add multiply or restoring divide iteration
module muldiv_step #(
    parameter int BitWidth = 32
) (
    input  logic [2*BitWidth-1:0] accumulator,
    input  logic [BitWidth-1:0]   operand,
    input  logic                  mode,
    output logic [2*BitWidth-1:0] nextAccumulator,
    output logic                  quotientBit
);

    logic [BitWidth:0] sum;
    logic [BitWidth:0] shifted;
    logic [BitWidth:0] difference;

    // mode=0: add multiplicand when the current multiplier bit is set, then shift right.
    // mode=1: shift the remainder left, pull in the next dividend bit, subtract if it fits.
    always_comb begin
        sum        = {1'b0, accumulator[2*BitWidth-1:BitWidth]}
                   + (accumulator[0] ? {1'b0, operand} : {(BitWidth+1){1'b0}});
        shifted    = {accumulator[2*BitWidth-1:BitWidth], accumulator[BitWidth-1]};
        difference = shifted - {1'b0, operand};
        nextAccumulator = '0;
        quotientBit     = 1'b0;
        if (mode) begin
            if (shifted >= {1'b0, operand}) begin
                quotientBit     = 1'b1;
                nextAccumulator = {difference[BitWidth-1:0], accumulator[BitWidth-2:0], 1'b0};
            end else begin
                nextAccumulator = {shifted[BitWidth-1:0], accumulator[BitWidth-2:0], 1'b0};
            end
        end else begin
            nextAccumulator = {sum, accumulator[BitWidth-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MIPS multiply/divide unit with HI/LO registers
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int BitWidth = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                start,
    input  MulDivOp             op,
    input  logic [BitWidth-1:0] operandA,
    input  logic [BitWidth-1:0] operandB,
    input  logic                hiWrite,
    input  logic                loWrite,
    input  logic [BitWidth-1:0] wData,
    output logic                busy,
    output logic                done,
    output logic                divByZero,
    output logic [BitWidth-1:0] hi,
    output logic [BitWidth-1:0] lo
);

    localparam int CountWidth = GetMinWidth(BitWidth);
    localparam logic [CountWidth-1:0] LastCount = CountWidth'(BitWidth - 1);

    MulDivState              state;
    logic [CountWidth-1:0]   counter;
    logic [2*BitWidth-1:0]   acc;
    logic [BitWidth-1:0]     operandReg;
    logic [BitWidth-1:0]     rawA;
    logic                    isDivide;
    logic                    resultSign;
    logic                    remSign;
    logic                    divZero;
    logic [BitWidth-1:0]     hiReg;
    logic [BitWidth-1:0]     loReg;
    logic                    doneReg;
    logic                    dbzReg;

    logic                    signedOp;
    logic                    divOp;
    logic [BitWidth-1:0]     magA;
    logic [BitWidth-1:0]     magB;
    logic [2*BitWidth-1:0]   stepAcc;
    logic                    stepBit;
    logic [2*BitWidth-1:0]   product;
    logic [BitWidth-1:0]     quotient;
    logic [BitWidth-1:0]     remainder;
    logic [BitWidth-1:0]     finalHi;
    logic [BitWidth-1:0]     finalLo;

    // Decode the issuing op and take operand magnitudes for the signed variants.
    always_comb begin
        signedOp = (op == MULT) || (op == DIV);
        divOp    = (op == DIV) || (op == DIVU);
        magA     = (signedOp && operandA[BitWidth-1]) ? (~operandA + 1'b1) : operandA;
        magB     = (signedOp && operandB[BitWidth-1]) ? (~operandB + 1'b1) : operandB;
    end

    muldiv_step #(
        .BitWidth(BitWidth)
    ) stepUnit (
        .accumulator    (acc),
        .operand        (operandReg),
        .mode           (isDivide),
        .nextAccumulator(stepAcc),
        .quotientBit    (stepBit)
    );

    // Sign-correct the magnitude result; a zero divisor overrides with the fixed pattern.
    always_comb begin
        product   = resultSign ? (~acc + 1'b1) : acc;
        quotient  = resultSign ? (~acc[BitWidth-1:0] + 1'b1) : acc[BitWidth-1:0];
        remainder = remSign ? (~acc[2*BitWidth-1:BitWidth] + 1'b1) : acc[2*BitWidth-1:BitWidth];
        finalHi   = product[2*BitWidth-1:BitWidth];
        finalLo   = product[BitWidth-1:0];
        if (divZero) begin
            finalHi = rawA;
            finalLo = '1;
        end else if (isDivide) begin
            finalHi = remainder;
            finalLo = quotient;
        end
    end

    // Control FSM, iteration counter, datapath registers and architectural HI/LO.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            counter    <= '0;
            acc        <= '0;
            operandReg <= '0;
            rawA       <= '0;
            isDivide   <= 1'b0;
            resultSign <= 1'b0;
            remSign    <= 1'b0;
            divZero    <= 1'b0;
            hiReg      <= '0;
            loReg      <= '0;
            doneReg    <= 1'b0;
            dbzReg     <= 1'b0;
        end else if (enable) begin
            doneReg <= 1'b0;
            dbzReg  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc        <= {{BitWidth{1'b0}}, (divOp ? magA : magB)};
                        operandReg <= divOp ? magB : magA;
                        rawA       <= operandA;
                        isDivide   <= divOp;
                        resultSign <= signedOp && (operandA[BitWidth-1] ^ operandB[BitWidth-1]);
                        remSign    <= signedOp && operandA[BitWidth-1];
                        divZero    <= divOp && (operandB == '0);
                        counter    <= '0;
                        state      <= COMPUTE;
                    end else begin
                        if (hiWrite) hiReg <= wData;
                        if (loWrite) loReg <= wData;
                    end
                end
                COMPUTE: begin
                    acc     <= {stepAcc[2*BitWidth-1:1], stepAcc[0] | stepBit};
                    counter <= counter + 1'b1;
                    if (counter == LastCount) state <= FINISH;
                end
                FINISH: begin
                    hiReg   <= finalHi;
                    loReg   <= finalLo;
                    doneReg <= 1'b1;
                    dbzReg  <= divZero;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end else begin
            doneReg <= 1'b0;
            dbzReg  <= 1'b0;
        end
    end

    assign busy      = (state != IDLE);
    assign done      = doneReg;
    assign divByZero = dbzReg;
    assign hi        = enable ? hiReg : {BitWidth{1'bz}};
    assign lo        = enable ? loReg : {BitWidth{1'bz}};

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative MIPS multiply/divide unit with architectural HI/LO registers.
- Consumes the two register-file read operands (rs, rt) for MULT/MULTU/DIV/DIVU.
- Holds the HI/LO results for MFHI/MFLO, whose data returns to the register-file write port through the writeback mux.
- Multi-cycle: raises busy so the pipeline stalls MFHI/MFLO and new mul/div issue.

Parameters:
- BitWidth, 32, operand and HI/LO width.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- enable  input  1  0 freezes all state; hi/lo outputs driven 'z.
- start  input  1  issue request; accepted only when enable=1 and busy=0.
- op  input  2  MulDivOp: MULT=0, MULTU=1, DIV=2, DIVU=3; sampled with start.
- operandA  input  BitWidth  rs value (multiplicand or dividend).
- operandB  input  BitWidth  rt value (multiplier or divisor).
- hiWrite  input  1  MTHI strobe.
- loWrite  input  1  MTLO strobe.
- wData  input  BitWidth  MTHI/MTLO data.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse when new HI/LO are visible.
- divByZero  output  1  pulses with done when a divide had divisor 0.
- hi  output  BitWidth  HI register.
- lo  output  BitWidth  LO register.

Behaviour:
Reset
- reset=0: state=IDLE, counter=0, HI=LO=0, busy=0, done=0, divByZero=0.
- A reset asserted mid-operation aborts the operation. No result is written.

State machine
- States: IDLE, COMPUTE, FINISH.
- busy = (state != IDLE).
- IDLE: start accepted at edge E0.
  - Latch the operand magnitudes: abs() for MULT/DIV, raw for MULTU/DIVU.
  - Latch the result signs: product sign = signA^signB; quotient sign = signA^signB; remainder sign = signA.
  - Clear the counter. Next state COMPUTE.
- COMPUTE: exactly BitWidth cycles. Counter width is GetMinWidth(BitWidth).
  - Multiply: shift-add, one multiplier bit per cycle, into a 2*BitWidth accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - At edge E0+BitWidth: next state FINISH.
- FINISH: apply sign correction (two's-complement negate where the latched sign is 1).
  - At edge E0+BitWidth+1: write HI/LO, go to IDLE, done=1 for exactly one cycle.
  - busy is high from E0 to E0+BitWidth+1 (BitWidth+1 cycles).
  - done is high between E0+BitWidth+1 and E0+BitWidth+2.
  - New hi/lo are visible in the same cycle as done.

Results
- Multiply: HI = upper BitWidth bits of the product, LO = lower BitWidth bits.
- Divide: LO = quotient, HI = remainder.
- Signed overflow (min-int / -1): LO = min-int, HI = 0. This falls out of the magnitude path.
- Divide by zero: detected at start. The unit still runs the full latency. Result LO = all ones, HI = operandA (raw). divByZero pulses with done.

Boundaries and priorities
- start while busy: ignored, no queueing.
- hiWrite/loWrite while idle: HI/LO updated at the edge.
- hiWrite/loWrite while busy: ignored.
- start and hiWrite/loWrite in the same idle cycle: start wins, writes dropped.
- hiWrite and loWrite together: both written with wData.
- enable=0: state, counter, accumulators and HI/LO are held. done is held at 0. busy stays driven. hi/lo are 'z.
- Operation resumes when enable returns to 1. Latency is counted in enabled cycles.

Decomposition:
- Shared enum package: MulDivOp enum, alongside the existing ClockEdge enum.
- Counter width comes from Function::GetMinWidth.
- One sub-module, muldiv_step: a combinational single-iteration datapath.
  - Inputs: accumulator, operand, mode.
  - Outputs: next accumulator/remainder and quotient bit.
- The FSM, counter, sign fix and HI/LO stay in mult_div_unit.

Test Plan:
1. MULTU 0xFFFFFFFF x 0xFFFFFFFF, start at E0 -> busy from E0 to E33; done high E33-E34; HI=0xFFFFFFFE, LO=0x00000001.
2. MULT 0xFFFFFFFD (-3) x 0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0x00000000.
3. DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1.
4. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, divByZero=0. DIVU 0x1234 / 0 -> LO=0xFFFFFFFF, HI=0x1234, divByZero=1 coincident with done.
5. Start DIVU; at cycle 5 pulse start (MULTU) and hiWrite with wData=0xAA -> both ignored; the DIVU result is unchanged. In idle, hiWrite with 0xAA -> hi=0xAA next cycle. start+loWrite together -> loWrite dropped.
6. Reset driven to 0 at cycle 10 of a MULT -> busy, done, HI, LO = 0 immediately, without waiting for a clock edge. Separately, drop enable for 3 cycles mid-op -> hi/lo='z, and done arrives 3 cycles late with the correct result.
